mem_arbiter: RTL and testbench
==============================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 255, meaning the number of BUSY cycles without mem_valid before an error response (0 = timeout disabled).
REQ-002 SHALL have ports clk  in  1  rising-edge clock; reset  in  1  synchronous active-high reset.
REQ-003 SHALL have ports f_req  in  1  fetch request (held until f_valid); f_addr  in  32  fetch address (read-only requester).
REQ-004 SHALL have ports f_rdata  out  16  fetch read data; f_valid  out  1  one-cycle response pulse; f_err  out  1  timeout flag qualified by f_valid.
REQ-005 SHALL have ports l_req  in  1  LSU request; l_addr  in  32  address; l_wdata  in  16  store data; l_mask  in  2  byte mask; l_write  in  1  store=1/load=0.
REQ-006 SHALL have ports l_rdata  out  16  load data; l_valid  out  1  one-cycle response pulse; l_err  out  1  timeout flag qualified by l_valid.
REQ-007 SHALL have ports mem_req  out  1  transaction outstanding; mem_addr  out  32; mem_data_out  out  16; mem_mask  out  2; mem_write  out  1; mem_data_in  in  16; mem_valid  in  1  memory completion.
REQ-008 SHALL have ports state  out  2  arb_state_t; owner  out  1  arb_owner_t of current/last grant.

Function
REQ-009 SHALL implement states ARB_IDLE, ARB_BUSY, ARB_DONE.
REQ-010 In IDLE with any req high, SHALL grant one requester, register its addr/data/mask/write (fetch: mem_write=0, mask=2'b11, data 0) onto mem_*, set mem_req=1, go BUSY.
REQ-011 Request sampled at cycle N SHALL give mem_req=1 at N+1; mem_* SHALL stay stable while BUSY.
REQ-012 In BUSY on mem_valid SHALL register mem_data_in to owner's rdata, pulse owner's valid for exactly one cycle, clear mem_req and mem_write, go DONE.
REQ-013 DONE SHALL last one cycle, grant nothing, then return to IDLE; requester drops req during DONE.
REQ-014 The non-owner's valid/err SHALL stay 0; rdata of both SHALL hold last value.
REQ-015 mem_valid in IDLE or DONE SHALL be ignored.
REQ-016 With TIMEOUT_CYCLES>0, a BUSY counter SHALL count from 0; reaching TIMEOUT_CYCLES without mem_valid SHALL pulse owner valid+err, rdata=16'h0000, clear mem_req, go DONE.
REQ-017 mem_valid in the same cycle as the timeout limit SHALL win: normal response, err=0.
REQ-018 Counter SHALL clear on every grant; it SHALL not increment outside BUSY.
REQ-019 A req change while BUSY SHALL not affect the active transaction.

Reset
REQ-020 Reset SHALL force state=IDLE, owner=FETCH, mem_req=0, mem_write=0, mem_addr=0, mem_data_out=0, mem_mask=0, all rdata=0, valid/err=0, counter=0.
REQ-021 Reset mid-transaction SHALL abandon it with no valid pulse to either requester.

Configuration
REQ-022 With MEM_ARB_ROUND_ROBIN_EN defined, simultaneous requests SHALL grant the requester not granted last (owner register); after reset LSU wins the first tie.
REQ-023 Without MEM_ARB_ROUND_ROBIN_EN, simultaneous requests SHALL always grant LSU.
REQ-024 Single requests SHALL be granted identically in both builds.

Structure
REQ-025 arb_state_t, arb_owner_t (ARB_FETCH=0, ARB_LSU=1) and mask constants SHALL live in shared package mem_pkg.
REQ-026 Timeout counter SHALL be sub-module mem_arb_timer (clear, enable, limit in; expired out).

Verification
REQ-027 Fetch only: f_req, f_addr=32'h0000_0100, mem_valid 3 cycles after mem_req, data 16'hBEEF -> f_rdata=16'hBEEF, f_valid one cycle, l_valid=0.
REQ-028 LSU store: l_addr=32'h0001_0020, l_wdata=16'h1234, l_mask=2'b11, l_write=1 -> mem_write=1, mem_addr=32'h0001_0020 until mem_valid, then l_valid pulse, mem_write=0.
REQ-029 Both req every cycle, 4 transactions: RR build -> L,F,L,F; fixed build -> L,L,L,L.
REQ-030 TIMEOUT_CYCLES=4, no mem_valid -> after 4 BUSY cycles owner valid+err, rdata=0, mem_req=0; mem_valid coincident with 4th cycle -> err=0.
REQ-031 Reset asserted 2 cycles into BUSY -> all outputs reset values, no valid pulse, next request granted normally.

Source files
------------

// File: rtl/mem_pkg.sv
// Shared types and constants for the memory arbiter slice.
//   arb_state_t : arbiter FSM state as seen on the 'state' port
//   arb_owner_t : requester that holds, or last held, the memory port
//   MASK_*      : byte-mask constants for the 16-bit memory bus
//   TMR_W       : width of the BUSY timeout counter and its limit
//   pick_owner  : arbitration rule for one IDLE-cycle grant decision
package mem_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE = 2'd0,
    ARB_BUSY = 2'd1,
    ARB_DONE = 2'd2
  } arb_state_t;

  typedef enum logic {
    ARB_FETCH = 1'b0,
    ARB_LSU   = 1'b1
  } arb_owner_t;

  localparam logic [1:0] MASK_NONE = 2'b00;
  localparam logic [1:0] MASK_ALL  = 2'b11;

  localparam int unsigned TMR_W = 16;

  // A lone requester always wins. On a tie, round-robin hands the port to
  // whoever was not granted last; fixed priority always favours the LSU.
  function automatic arb_owner_t pick_owner(input logic       f_req,
                                            input logic       l_req,
                                            input arb_owner_t last,
                                            input logic       rr_en);
    arb_owner_t sel;
    if (f_req && !l_req)      sel = ARB_FETCH;
    else if (l_req && !f_req) sel = ARB_LSU;
    else if (rr_en)           sel = (last == ARB_FETCH) ? ARB_LSU : ARB_FETCH;
    else                      sel = ARB_LSU;
    return sel;
  endfunction

endpackage

// File: rtl/mem_arbiter_if.sv
// Memory-side bus of the arbiter.
//   master : arbiter side  (drives mem_req/addr/data_out/mask/write,
//                           receives mem_data_in/mem_valid)
//   slave  : memory side   (the reverse)
interface mem_arbiter_if;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic [15:0] mem_data_out;
  logic [1:0]  mem_mask;
  logic        mem_write;
  logic [15:0] mem_data_in;
  logic        mem_valid;

  modport master (
    output mem_req, mem_addr, mem_data_out, mem_mask, mem_write,
    input  mem_data_in, mem_valid
  );

  modport slave (
    input  mem_req, mem_addr, mem_data_out, mem_mask, mem_write,
    output mem_data_in, mem_valid
  );
endinterface

// File: rtl/mem_arb_timer.sv
// BUSY-phase timeout counter for mem_arbiter.
//   clk, reset : clock and synchronous active-high reset
//   clear      : restart the count from zero (asserted on every grant)
//   enable     : count this cycle (asserted only while BUSY)
//   limit      : number of enabled cycles until expiry; 0 disables expiry
//   expired    : high during the enabled cycle that reaches the limit
module mem_arb_timer
  import mem_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             enable,
  input  logic [TMR_W-1:0] limit,
  output logic             expired
);

  logic [TMR_W-1:0] count;

  always_ff @(posedge clk) begin
    if (reset || clear) count <= '0;
    else if (enable)    count <= count + 1'b1;
  end

  // count holds the number of completed enabled cycles, so the cycle in
  // which count == limit-1 is the limit-th one.
  assign expired = enable && (limit != '0) && (count == limit - 1'b1);

endmodule

// File: rtl/mem_arbiter.sv
// Two-requester memory arbiter: instruction fetch (read-only) and LSU
// share a single 16-bit memory port, one transaction at a time.
//   clk, reset            : clock and synchronous active-high reset
//   f_req/f_addr          : fetch request, held until f_valid
//   f_rdata/f_valid/f_err : fetch response (valid is a 1-cycle pulse)
//   l_req/l_addr/l_wdata/l_mask/l_write : LSU request
//   l_rdata/l_valid/l_err : LSU response
//   mem                   : memory bus (mem_arbiter_if.master)
//   state, owner          : FSM state and current/last grant owner
// Parameter TIMEOUT_CYCLES: BUSY cycles without mem_valid before an error
// response (0 disables the timeout).
// Build option MEM_ARB_ROUND_ROBIN_EN: alternate grants on simultaneous
// requests; otherwise the LSU always wins a tie.
module mem_arbiter
  import mem_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          f_req,
  input  logic [31:0]   f_addr,
  output logic [15:0]   f_rdata,
  output logic          f_valid,
  output logic          f_err,
  input  logic          l_req,
  input  logic [31:0]   l_addr,
  input  logic [15:0]   l_wdata,
  input  logic [1:0]    l_mask,
  input  logic          l_write,
  output logic [15:0]   l_rdata,
  output logic          l_valid,
  output logic          l_err,
  mem_arbiter_if.master mem,
  output arb_state_t    state,
  output arb_owner_t    owner
);

`ifdef MEM_ARB_ROUND_ROBIN_EN
  localparam logic RR_EN = 1'b1;
`else
  localparam logic RR_EN = 1'b0;
`endif

  localparam logic [TMR_W-1:0] LIMIT = TMR_W'(TIMEOUT_CYCLES);

  logic       grant;
  logic       busy;
  logic       expired;
  arb_owner_t next_owner;

  assign grant      = (state == ARB_IDLE) && (f_req || l_req);
  assign busy       = (state == ARB_BUSY);
  assign next_owner = pick_owner(f_req, l_req, owner, RR_EN);

  mem_arb_timer u_timer (
    .clk     (clk),
    .reset   (reset),
    .clear   (grant),
    .enable  (busy),
    .limit   (LIMIT),
    .expired (expired)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state            <= ARB_IDLE;
      owner            <= ARB_FETCH;
      mem.mem_req      <= 1'b0;
      mem.mem_write    <= 1'b0;
      mem.mem_addr     <= '0;
      mem.mem_data_out <= '0;
      mem.mem_mask     <= MASK_NONE;
      f_rdata          <= '0;
      l_rdata          <= '0;
      f_valid          <= 1'b0;
      f_err            <= 1'b0;
      l_valid          <= 1'b0;
      l_err            <= 1'b0;
    end else begin
      f_valid <= 1'b0;
      f_err   <= 1'b0;
      l_valid <= 1'b0;
      l_err   <= 1'b0;

      unique case (state)
        ARB_IDLE: begin
          if (grant) begin
            owner       <= next_owner;
            mem.mem_req <= 1'b1;
            if (next_owner == ARB_LSU) begin
              mem.mem_addr     <= l_addr;
              mem.mem_data_out <= l_wdata;
              mem.mem_mask     <= l_mask;
              mem.mem_write    <= l_write;
            end else begin
              mem.mem_addr     <= f_addr;
              mem.mem_data_out <= '0;
              mem.mem_mask     <= MASK_ALL;
              mem.mem_write    <= 1'b0;
            end
            state <= ARB_BUSY;
          end
        end

        ARB_BUSY: begin
          // A completion in the limit cycle takes precedence over the timeout.
          if (mem.mem_valid || expired) begin
            mem.mem_req   <= 1'b0;
            mem.mem_write <= 1'b0;
            if (owner == ARB_LSU) begin
              l_rdata <= mem.mem_valid ? mem.mem_data_in : 16'h0000;
              l_valid <= 1'b1;
              l_err   <= !mem.mem_valid;
            end else begin
              f_rdata <= mem.mem_valid ? mem.mem_data_in : 16'h0000;
              f_valid <= 1'b1;
              f_err   <= !mem.mem_valid;
            end
            state <= ARB_DONE;
          end
        end

        ARB_DONE: state <= ARB_IDLE;

        default:  state <= ARB_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter (TIMEOUT_CYCLES = 4). Expected
// behaviour comes from a transaction-level model: arbitration by rule,
// latency vs. timeout by arithmetic, last response data per requester.
// Honours MEM_ARB_ROUND_ROBIN_EN the same way the design build does.
module tb_mem_arbiter;
  import mem_pkg::*;

  localparam int unsigned TO = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        f_req, l_req, l_write;
  logic [31:0] f_addr, l_addr;
  logic [15:0] l_wdata, f_rdata, l_rdata;
  logic [1:0]  l_mask;
  logic        f_valid, f_err, l_valid, l_err;
  arb_state_t  state;
  arb_owner_t  owner;

  mem_arbiter_if mem_bus ();

  mem_arbiter #(.TIMEOUT_CYCLES(TO)) dut (
    .clk     (clk),
    .reset   (reset),
    .f_req   (f_req),
    .f_addr  (f_addr),
    .f_rdata (f_rdata),
    .f_valid (f_valid),
    .f_err   (f_err),
    .l_req   (l_req),
    .l_addr  (l_addr),
    .l_wdata (l_wdata),
    .l_mask  (l_mask),
    .l_write (l_write),
    .l_rdata (l_rdata),
    .l_valid (l_valid),
    .l_err   (l_err),
    .mem     (mem_bus.master),
    .state   (state),
    .owner   (owner)
  );

  always #5 clk = ~clk;

  int unsigned n_total = 0;
  int unsigned n_pass  = 0;

  // Model state
  logic        m_last_lsu;
  logic [15:0] m_f_rdata, m_l_rdata;

`ifdef MEM_ARB_ROUND_ROBIN_EN
  localparam bit M_RR = 1'b1;
`else
  localparam bit M_RR = 1'b0;
`endif

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, " state"},  32'(state), 32'(ARB_IDLE));
    check({tag, " owner"},  32'(owner), 32'(ARB_FETCH));
    check({tag, " mem_req"}, 32'(mem_bus.mem_req), 32'd0);
    check({tag, " mem_write"}, 32'(mem_bus.mem_write), 32'd0);
    check({tag, " mem_addr"}, mem_bus.mem_addr, 32'd0);
    check({tag, " mem_data_out"}, 32'(mem_bus.mem_data_out), 32'd0);
    check({tag, " mem_mask"}, 32'(mem_bus.mem_mask), 32'd0);
    check({tag, " rdata"}, {f_rdata, l_rdata}, 32'd0);
    check({tag, " valid/err"}, {28'd0, f_valid, f_err, l_valid, l_err}, 32'd0);
  endtask

  // Starts at a negedge with the DUT idle; ends at the negedge after DONE.
  // lat = number of BUSY cycles before the one carrying mem_valid;
  // lat >= TO means memory never answers.
  task automatic run_txn(input logic fr, input logic lr, input int unsigned lat,
                         input bit hold, input logic [15:0] rdv);
    logic        exp_lsu, timed_out;
    logic [31:0] e_addr;
    logic [15:0] e_data, e_rdata;
    logic [1:0]  e_mask;
    logic        e_write;
    int unsigned busy_cycles;

    f_req = fr;
    l_req = lr;
    check("idle state", 32'(state), 32'(ARB_IDLE));

    if (fr && !lr)      exp_lsu = 1'b0;
    else if (lr && !fr) exp_lsu = 1'b1;
    else                exp_lsu = M_RR ? !m_last_lsu : 1'b1;

    e_addr  = exp_lsu ? l_addr  : f_addr;
    e_data  = exp_lsu ? l_wdata : 16'h0000;
    e_mask  = exp_lsu ? l_mask  : 2'b11;
    e_write = exp_lsu ? l_write : 1'b0;
    timed_out   = (lat >= TO);
    busy_cycles = timed_out ? TO : lat + 1;
    e_rdata     = timed_out ? 16'h0000 : rdv;

    @(negedge clk);
    for (int unsigned k = 1; k <= busy_cycles; k++) begin
      check("busy state", 32'(state), 32'(ARB_BUSY));
      check("busy owner", 32'(owner), 32'(exp_lsu));
      check("mem_req", 32'(mem_bus.mem_req), 32'd1);
      check("mem_addr", mem_bus.mem_addr, e_addr);
      check("mem_data/mask/write",
            {13'd0, mem_bus.mem_data_out, mem_bus.mem_mask, mem_bus.mem_write},
            {13'd0, e_data, e_mask, e_write});
      check("busy valids", {30'd0, f_valid, l_valid}, 32'd0);
      // Requester-side churn must not disturb the active transaction.
      f_addr  = $urandom;
      l_addr  = $urandom;
      l_wdata = 16'($urandom);
      l_mask  = 2'($urandom);
      l_write = 1'($urandom);
      if (!hold) begin
        if (exp_lsu) f_req = 1'($urandom);
        else         l_req = 1'($urandom);
      end
      if (k == lat + 1) begin
        mem_bus.mem_valid   = 1'b1;
        mem_bus.mem_data_in = rdv;
      end
      @(negedge clk);
      mem_bus.mem_valid   = 1'b0;
      mem_bus.mem_data_in = 16'($urandom);
    end

    // DONE cycle: response pulse for the owner only.
    if (exp_lsu) m_l_rdata = e_rdata;
    else         m_f_rdata = e_rdata;
    m_last_lsu = exp_lsu;
    check("done state", 32'(state), 32'(ARB_DONE));
    check("done mem_req/write", {30'd0, mem_bus.mem_req, mem_bus.mem_write}, 32'd0);
    check("f valid/err", {30'd0, f_valid, f_err}, {30'd0, !exp_lsu, !exp_lsu && timed_out});
    check("l valid/err", {30'd0, l_valid, l_err}, {30'd0, exp_lsu, exp_lsu && timed_out});
    check("done rdata", {f_rdata, l_rdata}, {m_f_rdata, m_l_rdata});
    // Stray completion during DONE must be ignored.
    mem_bus.mem_valid   = 1'($urandom);
    mem_bus.mem_data_in = 16'($urandom);
    if (!hold) begin
      f_req = 1'b0;
      l_req = 1'b0;
    end
    @(negedge clk);
    mem_bus.mem_valid = 1'b0;
    check("post state", 32'(state), 32'(ARB_IDLE));
    check("post valids", {28'd0, f_valid, f_err, l_valid, l_err}, 32'd0);
    check("post rdata hold", {f_rdata, l_rdata}, {m_f_rdata, m_l_rdata});
  endtask

  initial begin
    reset = 1'b1;
    f_req = 1'b0; l_req = 1'b0; l_write = 1'b0;
    f_addr = '0; l_addr = '0; l_wdata = '0; l_mask = '0;
    mem_bus.mem_valid = 1'b0;
    mem_bus.mem_data_in = '0;
    m_last_lsu = 1'b0;
    m_f_rdata = '0;
    m_l_rdata = '0;

    repeat (2) @(negedge clk);
    check_reset_values("reset");
    reset = 1'b0;
    @(negedge clk);

    // mem_valid while idle with no request: nothing happens.
    mem_bus.mem_valid   = 1'b1;
    mem_bus.mem_data_in = 16'hDEAD;
    @(negedge clk);
    mem_bus.mem_valid = 1'b0;
    check("idle ignore state", 32'(state), 32'(ARB_IDLE));
    check("idle ignore out", {12'd0, f_rdata, f_valid, f_err, l_valid, l_err}, 32'd0);

    // Fetch only, completion 3 cycles after mem_req rises (limit cycle).
    f_addr = 32'h0000_0100;
    run_txn(1'b1, 1'b0, 3, 1'b0, 16'hBEEF);

    // LSU store.
    l_addr = 32'h0001_0020; l_wdata = 16'h1234; l_mask = 2'b11; l_write = 1'b1;
    run_txn(1'b0, 1'b1, 1, 1'b0, 16'h5A5A);

    // Timeouts for each requester, then an immediate completion.
    l_addr = 32'hCAFE_0000; l_wdata = 16'h7777; l_mask = 2'b01; l_write = 1'b0;
    run_txn(1'b0, 1'b1, TO, 1'b0, 16'hFFFF);
    f_addr = 32'h0000_0200;
    run_txn(1'b1, 1'b0, TO + 3, 1'b0, 16'hFFFF);
    run_txn(1'b1, 1'b0, 0, 1'b0, 16'h0F0F);

    // Both requesting every cycle for four transactions.
    for (int i = 0; i < 4; i++) begin
      f_addr = $urandom; l_addr = $urandom; l_wdata = 16'($urandom);
      run_txn(1'b1, 1'b1, $urandom_range(0, 2), 1'b1, 16'($urandom));
    end
    f_req = 1'b0;
    l_req = 1'b0;
    @(negedge clk);

    // Reset two cycles into BUSY abandons the transaction.
    l_addr = 32'h1111_2222; l_wdata = 16'hABCD; l_mask = 2'b10; l_write = 1'b1;
    l_req = 1'b1;
    repeat (2) @(negedge clk);
    check("pre-reset busy", 32'(state), 32'(ARB_BUSY));
    reset = 1'b1;
    l_req = 1'b0;
    mem_bus.mem_valid = 1'b1;
    @(negedge clk);
    mem_bus.mem_valid = 1'b0;
    check_reset_values("midreset");
    reset = 1'b0;
    m_last_lsu = 1'b0;
    m_f_rdata = '0;
    m_l_rdata = '0;
    @(negedge clk);
    check("after reset valids", {28'd0, f_valid, f_err, l_valid, l_err}, 32'd0);
    run_txn(1'b1, 1'b1, 1, 1'b0, 16'h2468);

    // Randomized traffic.
    for (int i = 0; i < 20; i++) begin
      logic fr, lr;
      fr = 1'($urandom);
      lr = fr ? 1'($urandom) : 1'b1;
      f_addr  = $urandom;
      l_addr  = $urandom;
      l_wdata = 16'($urandom);
      l_mask  = 2'($urandom);
      l_write = 1'($urandom);
      run_txn(fr, lr, $urandom_range(0, TO + 1), 1'b0, 16'($urandom));
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
